cntr8_ns_ctrl: RTL
==================

// Module: cntr8_ns_ctrl
// PURPOSE
//  Next-state logic plus state register for the 8-bit up/down/load counter (cntr8).
//  Turns the user commands (clear/load/inc/dec) into the 3-bit state code that the
//  output logic decodes into d_out.
//  INC/INC2 and DEC/DEC2 alternate so every count step is a visible state change.
//  STEP_DIV rate-limits steps for slow (human-visible) counting on the board.
// PARAMETERS
//  STEP_DIV  1  enabled cycles per count step while inc/dec is held (1..255)
//  DIV_W     8  width of the step prescaler counter
// PORTS
//  clk      in   1  rising-edge clock
//  reset    in   1  synchronous, active-high reset
//  i_clear  in   1  force IDLE (output logic drives 0)
//  i_load   in   1  enter LOAD (output logic captures d_in)
//  i_inc    in   1  count up
//  i_dec    in   1  count down
//  o_state  out  3  registered state code, feeds the output logic's state input
//  o_step   out  1  1-cycle pulse, high in the cycle o_state enters INC/INC2/DEC/DEC2
//  o_dir    out  1  1 = last step was up, 0 = down/none
// BEHAVIOUR
//  - Encoding: IDLE=000 LOAD=001 INC=010 INC2=011 DEC=100 DEC2=101; 110/111 illegal.
//  - Reset (sync, reset=1 at posedge):
//    o_state=IDLE, o_step=0, o_dir=0, prescaler=0.
//  - Command priority per cycle: clear > load > (inc&dec) > inc > dec > none.
//  - clear: next=IDLE; prescaler=0.
//  - load: next=LOAD; prescaler=0; load held keeps LOAD (no new state change).
//  - inc&dec together: hold current state, prescaler=0, no step.
//  - inc only: prescaler counts 0..STEP_DIV-1.
//    * At STEP_DIV-1: step fires and prescaler wraps to 0; next = INC2 if cur==INC,
//      else INC. The first step fires STEP_DIV cycles after inc is asserted.
//    * STEP_DIV=1: steps every cycle, alternating INC,INC2,INC,...
//  - dec only: same as inc, using DEC/DEC2.
//  - none: hold state; prescaler=0.
//  - Direction change (INC* -> DEC*): lands in DEC, never DEC2 (and vice versa).
//  - o_step/o_dir registered alongside o_state:
//    * o_step=1 exactly in the cycle after the step decision.
//    * o_dir updates only on a step.
//  - Illegal state (110/111): next=IDLE unconditionally, o_step=0.
//  - Latency: command sampled at posedge N gives o_state at N+1 (STEP_DIV=1).
//  - Reset mid-count overrides all commands.
//  - Wrap of the count value is owned by the output logic (8-bit modular). This block
//    is value-agnostic.
// STRUCTURE
//  - cntr8_states.vh: the six state codes (shared with the output logic);
//    replaces the per-file parameters.
//  - Sub-module cntr8_state_reg: 3-bit sync-reset register (reset value IDLE).
//    Next-state logic and prescaler stay in this module.
// TESTING
//  1. reset=1 2 cycles, all cmds 0 -> o_state=000, o_step=0, o_dir=0.
//  2. STEP_DIV=1, i_inc=1 for 4 cycles -> o_state 010,011,010,011; o_step=1 each; o_dir=1.
//  3. STEP_DIV=3, i_dec=1 for 7 cycles -> o_state=100 after cycle 3, 101 after cycle 6;
//     o_step pulses 2x.
//  4. i_inc=1 with i_load=1, then i_clear=1 with i_load=1 -> 001 then 000; no o_step.
//  5. In INC2, i_inc=i_dec=1 for 3 cycles -> state stays 011; then i_dec=1 -> 100 (not 101).
//  6. Force state 111 via bench, then reset mid-count at STEP_DIV=2 -> 000 next cycle;
//     prescaler restarts (2 cycles to first step).

Source files
------------

// File: rtl/cntr8_ns_ctrl_pkg.sv
// Shared definitions for the cntr8 next-state controller: state codes and
// a legality helper for the 3-bit state register.
package cntr8_ns_ctrl_pkg;

  // Six legal state codes. The output logic decodes these into d_out.
  // Codes 3'b110 and 3'b111 are illegal and force a return to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_LOAD = 3'b001,
    ST_INC  = 3'b010,
    ST_INC2 = 3'b011,
    ST_DEC  = 3'b100,
    ST_DEC2 = 3'b101
  } state_t;

  localparam int STATE_W = 3;

  // A raw register value is legal only when it is one of the six codes above.
  function automatic logic is_legal(input logic [STATE_W-1:0] code);
    return (code != 3'b110) && (code != 3'b111);
  endfunction

endpackage

// File: rtl/cntr8_ns_ctrl_state_reg.sv
// 3-bit state register for the cntr8 controller. Holds a raw code so that an
// illegal value, should one appear, stays visible to the next-state logic.
module cntr8_ns_ctrl_state_reg
  import cntr8_ns_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [STATE_W-1:0] next_state,
  output logic [STATE_W-1:0] state
);

  logic [STATE_W-1:0] state_q;

  // Capture the next state every cycle; synchronous reset returns to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/cntr8_ns_ctrl.sv
// Next-state logic, step prescaler and state register for the 8-bit
// up/down/load counter. Count steps alternate INC/INC2 (or DEC/DEC2) so that
// every step is a visible state change for the output logic.
module cntr8_ns_ctrl
  import cntr8_ns_ctrl_pkg::*;
#(
  parameter int STEP_DIV = 1,
  parameter int DIV_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clear,
  input  logic               i_load,
  input  logic               i_inc,
  input  logic               i_dec,
  output logic [STATE_W-1:0] o_state,
  output logic               o_step,
  output logic               o_dir
);

  // Prescaler value at which a held inc/dec produces a step.
  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(STEP_DIV - 1);

  logic [STATE_W-1:0] cur_state;
  logic [STATE_W-1:0] next_state;
  logic [DIV_W-1:0]   presc_q;
  logic [DIV_W-1:0]   presc_d;
  logic               step_q;
  logic               step_d;
  logic               dir_q;
  logic               dir_d;

  cntr8_ns_ctrl_state_reg u_state_reg (
    .clk        (clk),
    .reset      (reset),
    .next_state (next_state),
    .state      (cur_state)
  );

  // Prescaler, step pulse and direction are registered alongside the state so
  // o_step is high exactly in the cycle the state enters an INC*/DEC* code.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
    end
  end

  // Command priority: illegal state > clear > load > inc&dec > inc > dec > none.
  // Any command other than a lone inc/dec restarts the prescaler; a step toggles
  // between the pair, and a direction change always lands on the first code.
  always_comb begin
    next_state = cur_state;
    presc_d    = '0;
    step_d     = 1'b0;
    dir_d      = dir_q;
    if (!is_legal(cur_state)) begin
      next_state = ST_IDLE;
    end else if (i_clear) begin
      next_state = ST_IDLE;
    end else if (i_load) begin
      next_state = ST_LOAD;
    end else if (i_inc && i_dec) begin
      next_state = cur_state;
    end else if (i_inc || i_dec) begin
      if (presc_q == PRESC_LAST) begin
        step_d = 1'b1;
        dir_d  = i_inc;
        if (i_inc) begin
          next_state = (cur_state == ST_INC) ? ST_INC2 : ST_INC;
        end else begin
          next_state = (cur_state == ST_DEC) ? ST_DEC2 : ST_DEC;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // Outputs are straight copies of registered values, so they are glitch-free.
  always_comb begin
    o_state = cur_state;
    o_step  = step_q;
    o_dir   = dir_q;
  end

endmodule
